idct4_pipe: RTL and testbench

//  Pipelined 4-point HEVC inverse DCT: all four outputs of one row/column per beat.
//  - Even/odd butterfly with coefficients 64/83/36, rounding, arithmetic shift.
//  - Per-beat selectable row (first) or column (second) pass.
//  - Valid/ready streaming between the coefficient fetch stage and the transpose buffer.

---
 rtl/idct4_pipe.sv | 191 +++++++++++++++++++
 tb/tb_idct4_pipe.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/idct4_pipe.sv
// -----------------------------------------------------------------------------
// idct4_pipe
// Pipelined 4-point HEVC inverse DCT. One row or column of four coefficients
// is accepted per beat and all four samples are produced together.
//
// Pipeline:
//   S1 : even/odd partial products  E0,E1 (x0/x2 with 64) and O0,O1 (x1/x3 with 83/36)
//   S2 : butterfly                  y0..y3 = E +/- O
//   S3 : round, arithmetic shift and narrowing to OUT_W; drives the outputs
// Each beat carries its own col_sel, so row-pass and column-pass beats may
// be interleaved freely.
//
// Handshake: one global advance enable (en = !out_valid || out_ready). When
// en is low the whole pipe freezes, so the output beat stays stable until it
// is popped. in_ready is en itself (combinational).
//
// Optional build macro:
//   IDCT4_SAT_EN  defined   -> shifted result clamped to the OUT_W signed range
//                 undefined -> low OUT_W bits taken (two's-complement wrap)
//
// Ports:
//   clk        in   1      clock, rising edge
//   reset      in   1      asynchronous, active-high reset
//   in_valid   in   1      input beat valid
//   in_ready   out  1      beat accepted this cycle when in_valid is high
//   col_sel    in   1      0 = row pass (SHIFT_ROW), 1 = column pass (SHIFT_COL)
//   d_in_0..3  in   IN_W   signed coefficients x0..x3
//   out_valid  out  1      output beat valid
//   out_ready  in   1      downstream accepts the output beat
//   d_out_0..3 out  OUT_W  signed samples y0..y3
// -----------------------------------------------------------------------------
module idct4_pipe #(
  parameter int IN_W      = 16,
  parameter int OUT_W     = 16,
  parameter int ACC_W     = IN_W + 9,
  parameter int SHIFT_ROW = 7,
  parameter int SHIFT_COL = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    col_sel,
  input  logic signed [IN_W-1:0]  d_in_0,
  input  logic signed [IN_W-1:0]  d_in_1,
  input  logic signed [IN_W-1:0]  d_in_2,
  input  logic signed [IN_W-1:0]  d_in_3,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] d_out_0,
  output logic signed [OUT_W-1:0] d_out_1,
  output logic signed [OUT_W-1:0] d_out_2,
  output logic signed [OUT_W-1:0] d_out_3
);

  // Transform coefficients at accumulator width.
  localparam logic signed [ACC_W-1:0] C64 = ACC_W'(8'sd64);
  localparam logic signed [ACC_W-1:0] C83 = ACC_W'(8'sd83);
  localparam logic signed [ACC_W-1:0] C36 = ACC_W'(8'sd36);

  // Rounding offsets, one bit wider than the accumulator so the add cannot overflow.
  localparam logic signed [ACC_W:0] RND_ROW = {{ACC_W{1'b0}}, 1'b1} << (SHIFT_ROW - 1);
  localparam logic signed [ACC_W:0] RND_COL = {{ACC_W{1'b0}}, 1'b1} << (SHIFT_COL - 1);

  // OUT_W signed range limits, expressed at ACC_W+1 bits for comparison.
  localparam logic signed [ACC_W:0] OMAX_EXT = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] OMIN_EXT = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0]      OMAX     = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]      OMIN     = {1'b1, {(OUT_W-1){1'b0}}};

  // Narrow a shifted value to OUT_W: clamp in the saturating build, wrap otherwise.
  function automatic logic [OUT_W-1:0] narrow(input logic signed [ACC_W:0] v);
`ifdef IDCT4_SAT_EN
    if (v > OMAX_EXT) begin
      narrow = OMAX;
    end else if (v < OMIN_EXT) begin
      narrow = OMIN;
    end else begin
      narrow = v[OUT_W-1:0];
    end
`else
    narrow = v[OUT_W-1:0];
`endif
  endfunction

  logic                    en_s;
  logic signed [ACC_W-1:0] x_s [4];

  // S1 state
  logic                    v1_r;
  logic                    cs1_r;
  logic signed [ACC_W-1:0] e0_r, e1_r, o0_r, o1_r;

  // S2 state
  logic                    v2_r;
  logic                    cs2_r;
  logic signed [ACC_W-1:0] y_r [4];

  // S3 combinational inputs and state
  logic signed [ACC_W:0]   sum_s [4];
  logic signed [ACC_W:0]   shf_s [4];
  logic                    v3_r;
  logic [OUT_W-1:0]        d3_r [4];

  assign en_s     = !v3_r || out_ready;
  assign in_ready = en_s;

  assign out_valid = v3_r;
  assign d_out_0   = d3_r[0];
  assign d_out_1   = d3_r[1];
  assign d_out_2   = d3_r[2];
  assign d_out_3   = d3_r[3];

  // Sign-extend the input coefficients to accumulator width.
  always_comb begin
    x_s[0] = {{(ACC_W-IN_W){d_in_0[IN_W-1]}}, d_in_0};
    x_s[1] = {{(ACC_W-IN_W){d_in_1[IN_W-1]}}, d_in_1};
    x_s[2] = {{(ACC_W-IN_W){d_in_2[IN_W-1]}}, d_in_2};
    x_s[3] = {{(ACC_W-IN_W){d_in_3[IN_W-1]}}, d_in_3};
  end

  // S1: capture even/odd partial products and the beat's pass select.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_r  <= 1'b0;
      cs1_r <= 1'b0;
      e0_r  <= '0;
      e1_r  <= '0;
      o0_r  <= '0;
      o1_r  <= '0;
    end else if (en_s) begin
      v1_r  <= in_valid;
      cs1_r <= col_sel;
      e0_r  <= C64 * (x_s[0] + x_s[2]);
      e1_r  <= C64 * (x_s[0] - x_s[2]);
      o0_r  <= C83 * x_s[1] + C36 * x_s[3];
      o1_r  <= C36 * x_s[1] - C83 * x_s[3];
    end
  end

  // S2: even/odd butterfly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v2_r  <= 1'b0;
      cs2_r <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        y_r[k] <= '0;
      end
    end else if (en_s) begin
      v2_r   <= v1_r;
      cs2_r  <= cs1_r;
      y_r[0] <= e0_r + o0_r;
      y_r[1] <= e1_r + o1_r;
      y_r[2] <= e1_r - o1_r;
      y_r[3] <= e0_r - o0_r;
    end
  end

  // Round and shift each butterfly result with the shift belonging to its beat.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      sum_s[k] = '0;
      shf_s[k] = '0;
    end
    for (int k = 0; k < 4; k++) begin
      if (cs2_r) begin
        sum_s[k] = {y_r[k][ACC_W-1], y_r[k]} + RND_COL;
        shf_s[k] = sum_s[k] >>> SHIFT_COL;
      end else begin
        sum_s[k] = {y_r[k][ACC_W-1], y_r[k]} + RND_ROW;
        shf_s[k] = sum_s[k] >>> SHIFT_ROW;
      end
    end
  end

  // S3: output register; frozen while the current beat waits for out_ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v3_r <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        d3_r[k] <= '0;
      end
    end else if (en_s) begin
      v3_r <= v2_r;
      for (int k = 0; k < 4; k++) begin
        d3_r[k] <= narrow(shf_s[k]);
      end
    end
  end

endmodule

// File: tb/tb_idct4_pipe.sv
module tb_idct4_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        col_sel;
  logic signed [15:0] d_in_0, d_in_1, d_in_2, d_in_3;
  logic        out_valid;
  logic        out_ready;
  logic signed [15:0] d_out_0, d_out_1, d_out_2, d_out_3;

  idct4_pipe dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .col_sel(col_sel),
    .d_in_0(d_in_0), .d_in_1(d_in_1), .d_in_2(d_in_2), .d_in_3(d_in_3),
    .out_valid(out_valid), .out_ready(out_ready),
    .d_out_0(d_out_0), .d_out_1(d_out_1), .d_out_2(d_out_2), .d_out_3(d_out_3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][15:0] y;
    int               acc;
    int               st;
  } exp_t;

  exp_t             exp_q[$];
  logic [3:0][15:0] pops[$];
  int               total = 0;
  int               bad = 0;
  int               cyc_now = 0;
  int               stall_ctr = 0;
  logic             prev_stall = 1'b0;
  logic [3:0][15:0] prev_dout;
  logic [3:0][15:0] dout_s;

  assign dout_s = {d_out_3, d_out_2, d_out_1, d_out_0};

  // Reference: y = C^T x with the HEVC 4-point basis, then round/shift/narrow.
  function automatic logic [3:0][15:0] ref_y(input logic signed [15:0] x0, x1, x2, x3,
                                             input logic cs);
    int     c [4][4];
    longint xs [4];
    longint a, r;
    int     sh;
    logic [3:0][15:0] res;
    c = '{'{64, 64, 64, 64}, '{83, 36, -36, -83}, '{64, -64, -64, 64}, '{36, -83, 83, -36}};
    xs[0] = x0; xs[1] = x1; xs[2] = x2; xs[3] = x3;
    sh = cs ? 12 : 7;
    for (int k = 0; k < 4; k++) begin
      a = 0;
      for (int n = 0; n < 4; n++) a += longint'(c[n][k]) * xs[n];
      r = (a + (longint'(1) <<< (sh - 1))) >>> sh;
`ifdef IDCT4_SAT_EN
      if (r > 32767) r = 32767;
      else if (r < -32768) r = -32768;
`endif
      res[k] = r[15:0];
    end
    return res;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then clock.
  task automatic cyc(input logic v, input logic cs, input logic [15:0] x0, x1, x2, x3,
                     input logic ordy, output logic accepted);
    logic due;
    exp_t e;
    in_valid = v; col_sel = cs; out_ready = ordy;
    d_in_0 = x0; d_in_1 = x1; d_in_2 = x2; d_in_3 = x3;
    #1;
    // A beat is due when 3 cycles plus every stall since its acceptance have elapsed.
    due = (exp_q.size() > 0) && ((cyc_now - exp_q[0].acc - 3) == (stall_ctr - exp_q[0].st));
    chk("out_valid", out_valid, due);
    chk("in_ready", in_ready, !due || ordy);
    if (prev_stall) chk("hold", dout_s, prev_dout);
    if (due) chk("data", dout_s, exp_q[0].y);
    accepted = v && in_ready;
    if (due && ordy) begin
      e = exp_q.pop_front();
      pops.push_back(dout_s);
    end
    prev_stall = due && !ordy;
    if (prev_stall) stall_ctr++;
    prev_dout = dout_s;
    if (accepted) begin
      e.y = ref_y(x0, x1, x2, x3, cs);
      e.acc = cyc_now;
      e.st = stall_ctr;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc_now++;
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1, a);
  endtask

  task automatic do_reset();
    in_valid = 1'b0; out_ready = 1'b1; col_sel = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_dout", dout_s, 64'h0);
    exp_q.delete();
    prev_stall = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc_now++;
  endtask

  initial begin
    logic             a;
    logic [3:0][15:0] ev;
    logic [15:0]      xr [4];
    logic [31:0]      rv;
    int               sent;

    in_valid = 1'b0; col_sel = 1'b0; out_ready = 1'b1;
    d_in_0 = '0; d_in_1 = '0; d_in_2 = '0; d_in_3 = '0;
    reset = 1'b0;
    #2;
    do_reset();
    chk("rst_in_ready", in_ready, 1'b1);

    // Test 1: DC row beat.
    pops.delete();
    cyc(1'b1, 1'b0, 16'd64, 16'd0, 16'd0, 16'd0, 1'b1, a);
    idle(5);
    ev = {16'd32, 16'd32, 16'd32, 16'd32};
    chk("t1_count", pops.size(), 1);
    chk("t1_y", pops[0], ev);

    // Test 2: rounding and negative arithmetic shift.
    pops.delete();
    cyc(1'b1, 1'b0, 16'd0, 16'd1, 16'd0, 16'd0, 1'b1, a);
    idle(4);
    ev = {16'hFFFF, 16'h0000, 16'h0000, 16'h0001};
    chk("t2_y", pops[0], ev);

    // Test 3: column beat followed by a row beat; each keeps its own shift.
    pops.delete();
    cyc(1'b1, 1'b1, 16'd4096, 16'd0, 16'd0, 16'd0, 1'b1, a);
    cyc(1'b1, 1'b0, 16'd64, 16'd0, 16'd0, 16'd0, 1'b1, a);
    idle(5);
    ev = {16'd64, 16'd64, 16'd64, 16'd64};
    chk("t3_col", pops[0], ev);
    ev = {16'd32, 16'd32, 16'd32, 16'd32};
    chk("t3_row", pops[1], ev);

    // Test 4: full-scale input, saturation or wrap on y0.
    pops.delete();
    cyc(1'b1, 1'b0, 16'd32767, 16'd32767, 16'd32767, 16'd32767, 1'b1, a);
    idle(4);
`ifdef IDCT4_SAT_EN
    chk("t4_y0", pops[0][0], 16'h7FFF);
`else
    chk("t4_y0", pops[0][0], 16'hF6FE);
`endif

    // Test 5: 8 beats back-to-back with out_ready low for cycles 4-6.
    pops.delete();
    sent = 0;
    for (int i = 0; i < 6; i++) xr[i % 4] = 16'h0;
    for (int i = 0; i < 40 && sent < 8; i++) begin
      rv = $urandom; xr[0] = rv[15:0]; xr[1] = rv[31:16];
      rv = $urandom; xr[2] = rv[15:0]; xr[3] = rv[31:16];
      a = 1'b0;
      while (!a && i < 40) begin
        cyc(1'b1, sent[0], xr[0], xr[1], xr[2], xr[3], !(i >= 4 && i <= 6), a);
        if (!a) i++;
      end
      if (a) sent++;
    end
    chk("t5_sent", sent, 8);
    idle(6);
    chk("t5_count", pops.size(), 8);

    // Test 6: reset with two beats in flight.
    pops.delete();
    cyc(1'b1, 1'b0, 16'd64, 16'd0, 16'd0, 16'd0, 1'b1, a);
    cyc(1'b1, 1'b1, 16'd4096, 16'd0, 16'd0, 16'd0, 1'b1, a);
    idle(1);
    do_reset();
    cyc(1'b1, 1'b0, 16'd0, 16'd1, 16'd0, 16'd0, 1'b1, a);
    idle(5);
    chk("t6_count", pops.size(), 1);
    ev = {16'hFFFF, 16'h0000, 16'h0000, 16'h0001};
    chk("t6_fresh", pops[0], ev);

    // Randomized traffic with random back-pressure and occasional extreme values.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 4; k++) begin
        rv = $urandom;
        case (rv[31:30])
          2'd0:    xr[k] = (rv[0]) ? 16'h7FFF : 16'h8000;
          default: xr[k] = rv[15:0];
        endcase
      end
      rv = $urandom;
      cyc(rv[0] | rv[1], rv[2], xr[0], xr[1], xr[2], xr[3], rv[3] | rv[4], a);
    end
    idle(8);
    chk("drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
